// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the instruction-fetch responder.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr & XLEN'(3)) == '0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small in-order FIFO with synchronous reset, flush input and occupancy count.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_array [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_array[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
        count_d  = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !clear && !rst) begin
            mem_array[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: synchronous-read instruction store with a fixed
// read pipeline, an in-order response queue, credit-based flow control and flush.
module imem_responder
    import rv32i_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 2,
    parameter int    RSP_DEPTH   = 4,
    parameter string INIT_FILE   = "memfile.hex"
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic            kill,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_instr,
    output logic [XLEN-1:0] rsp_addr,
    output logic            rsp_err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int OCC_W = $clog2(RSP_DEPTH + 1);
    localparam int ENT_W = 2 * XLEN + 1;

    logic [XLEN-1:0] mem_array [DEPTH_WORDS];

    logic              flush, accept, consume, req_err;
    logic [IDX_W-1:0]  rd_idx;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [LATENCY-1:0] st_valid_q, st_valid_d;
    logic [LATENCY-1:0] st_err_q, st_err_d;
    logic [XLEN-1:0]   st_addr_q [LATENCY];
    logic [XLEN-1:0]   st_addr_d [LATENCY];
    logic [XLEN-1:0]   st_data_q [LATENCY];

    logic [ENT_W-1:0]  fifo_wdata, fifo_rdata;
    logic              fifo_empty, fifo_full;
    logic [OCC_W-1:0]  fifo_count;
    logic              unused_fifo;

    assign flush     = rst || kill;
    assign req_ready = !flush && (occ_q < OCC_W'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign consume   = rsp_valid && rsp_ready;
    assign rd_idx    = req_addr[IDX_W+1:2];
    assign req_err   = !is_word_aligned(req_addr)
                     || ({2'b00, req_addr[XLEN-1:2]} >= XLEN'(DEPTH_WORDS));

    // Occupancy counts in-flight plus queued responses, so the queue can never overflow.
    always_comb begin
        occ_d = occ_q + OCC_W'(accept) - OCC_W'(consume);
        if (flush) occ_d = '0;
    end

    always_comb begin
        st_valid_d[0] = accept;
        st_err_d[0]   = req_err;
        st_addr_d[0]  = req_addr;
        for (int i = 1; i < LATENCY; i++) begin
            st_valid_d[i] = st_valid_q[i-1];
            st_err_d[i]   = st_err_q[i-1];
            st_addr_d[i]  = st_addr_q[i-1];
        end
        if (flush) st_valid_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= '0;
            st_valid_q <= '0;
        end else begin
            occ_q      <= occ_d;
            st_valid_q <= st_valid_d;
        end
        st_err_q <= st_err_d;
        for (int i = 0; i < LATENCY; i++) begin
            st_addr_q[i] <= st_addr_d[i];
        end
    end

    // Registered memory read forms stage 0; error requests skip the array entirely.
    always_ff @(posedge clk) begin
        if (accept && !req_err) begin
            st_data_q[0] <= mem_array[rd_idx];
        end
        for (int i = 1; i < LATENCY; i++) begin
            st_data_q[i] <= st_data_q[i-1];
        end
    end

    assign fifo_wdata = {st_err_q[LATENCY-1], st_addr_q[LATENCY-1],
                         st_err_q[LATENCY-1] ? NOP_INSTR : st_data_q[LATENCY-1]};

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .wr_en   (st_valid_q[LATENCY-1]),
        .wr_data (fifo_wdata),
        .rd_en   (consume),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign unused_fifo = fifo_full ^ (^fifo_count);

    // Idle outputs read as zero rather than exposing stale queue contents.
    assign rsp_valid = !fifo_empty;
    assign {rsp_err, rsp_addr, rsp_instr} = rsp_valid ? fifo_rdata : '0;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: directed scenarios plus randomized traffic.
module tb_imem_responder;
    localparam int DEPTH_WORDS = 1024;
    localparam int LAT         = 2;
    localparam int RSP_DEPTH   = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        kill = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_instr, rsp_addr;

    imem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LAT),
        .RSP_DEPTH   (RSP_DEPTH),
        .INIT_FILE   ("")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .kill      (kill),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] model_mem [DEPTH_WORDS];
    int          checks = 0;
    int          errors = 0;

    function automatic exp_t model(input logic [31:0] a);
        exp_t e;
        e.addr  = a;
        e.err   = ((a % 4) != 0) || ((a / 4) >= DEPTH_WORDS);
        e.instr = NOP;
        if (!e.err) e.instr = model_mem[a[11:2]];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Accepted requests are sampled mid-cycle and enter the scoreboard at the edge.
    logic        acc_seen = 1'b0;
    logic [31:0] acc_addr = '0;
    always @(negedge clk) begin
        acc_seen = !rst && req_valid && req_ready;
        acc_addr = req_addr;
    end
    always @(posedge clk) begin
        if (acc_seen) exp_q.push_back(model(acc_addr));
    end

    // Monitor: flow control, hold stability and in-order response data.
    logic        hold_pend = 1'b0;
    logic [31:0] hold_instr, hold_addr;
    logic        hold_err;
    always @(negedge clk) begin
        check("req_ready", req_ready, !rst && !kill && (exp_q.size() < RSP_DEPTH));
        if (hold_pend) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_instr", rsp_instr, hold_instr);
            check("hold_addr", rsp_addr, hold_addr);
            check("hold_err", rsp_err, hold_err);
        end
        hold_pend  = rsp_valid && !rsp_ready && !kill && !rst;
        hold_instr = rsp_instr;
        hold_addr  = rsp_addr;
        hold_err   = rsp_err;
        if (rsp_valid && rsp_ready) begin
            $display("rsp addr=%h instr=%h err=%b", rsp_addr, rsp_instr, rsp_err);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_rsp: got addr %h expected no response", rsp_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_addr", rsp_addr, mon_e.addr);
                check("rsp_instr", rsp_instr, mon_e.instr);
                check("rsp_err", rsp_err, mon_e.err);
            end
        end
        if (rst || kill) exp_q.delete();
    end

    // Requests base, base+stride, ... back to back with rsp_ready high and an empty queue;
    // each response must appear exactly LAT cycles after its acceptance.
    task automatic burst(input int n, input logic [31:0] base, input logic [31:0] stride);
        exp_t e;
        for (int t = 0; t < n + LAT + 2; t++) begin
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            req_valid = (t < n);
            req_addr  = base + stride * t;
            @(negedge clk);
            if (t < n) check("burst_ready", req_ready, 1);
            check("burst_valid", rsp_valid, (t >= 1 + LAT) && (t < 1 + LAT + n));
            if ((t >= 1 + LAT) && (t < 1 + LAT + n)) begin
                e = model(base + stride * (t - 1 - LAT));
                check("burst_addr", rsp_addr, e.addr);
                check("burst_instr", rsp_instr, e.instr);
                check("burst_err", rsp_err, e.err);
            end
        end
        req_valid = 1'b0;
    endtask

    int acc_cnt, rsp_cnt, sel;

    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) model_mem[i] = $urandom;
        model_mem[0] = 32'h0050_0093;
        for (int i = 0; i < DEPTH_WORDS; i++) dut.mem_array[i] = model_mem[i];

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_instr", rsp_instr, 0);
        check("rst_rsp_addr", rsp_addr, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_req_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1);

        // Single fetch, then four back-to-back fetches
        burst(1, 32'h0, 32'h4);
        burst(4, 32'h0, 32'h4);

        // Back-pressure: only RSP_DEPTH requests are taken, then drained in order
        acc_cnt = 0;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            req_addr  = 32'h100 + 4 * t;
            @(negedge clk);
            if (req_valid && req_ready) acc_cnt++;
        end
        check("bp_accepts", acc_cnt, RSP_DEPTH);
        check("bp_ready_low", req_ready, 0);
        rsp_cnt = 0;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
            if (rsp_valid && rsp_ready) rsp_cnt++;
        end
        check("bp_drained", rsp_cnt, RSP_DEPTH);
        check("bp_ready_back", req_ready, 1);

        // Misaligned and out-of-range requests: 0x2 then 0x1000
        burst(2, 32'h2, 32'hFFE);

        // Kill with three requests in flight
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            req_addr  = 32'h10 + 4 * t;
        end
        @(posedge clk); #1;
        kill     = 1'b1;
        req_addr = 32'h20;
        @(negedge clk);
        check("kill_ready", req_ready, 0);
        @(posedge clk); #1;
        kill      = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("kill_rsp_valid", rsp_valid, 0);
        burst(1, 32'h40, 32'h4);

        // Reset with a full queue
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            req_addr  = 32'h200 + 4 * t;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstfull_valid", rsp_valid, 0);
        check("rstfull_instr", rsp_instr, 0);
        check("rstfull_addr", rsp_addr, 0);
        check("rstfull_err", rsp_err, 0);
        check("rstfull_ready", req_ready, 0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("rstfull_ready_back", req_ready, 1);

        // Randomized traffic
        repeat (2000) begin
            @(posedge clk); #1;
            req_valid = ($urandom_range(99) < 70);
            sel = $urandom_range(9);
            if (sel < 7)       req_addr = $urandom_range(DEPTH_WORDS - 1) * 4;
            else if (sel == 7) req_addr = $urandom_range(DEPTH_WORDS - 1) * 4 + $urandom_range(3, 1);
            else if (sel == 8) req_addr = 32'h1000 + $urandom_range(255) * 4;
            else               req_addr = $urandom;
            rsp_ready = ($urandom_range(99) < 60);
            kill      = ($urandom_range(99) < 2);
        end
        @(posedge clk); #1;
        kill      = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        check("drain_valid", rsp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
